util_adc_to_diff: RTL and testbench

//  Receive-side counterpart of the DAC differential encoder. Takes signed ADC sample words from the

---
 rtl/util_adc_to_diff.sv | 150 +++++++++++++++
 tb/tb_util_adc_to_diff.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/util_adc_to_diff.sv
// util_adc_to_diff: slices signed ADC samples into a 2-bit differential
// line state {pos,neg} with hysteresis and a consecutive-sample filter.
//
// Ports:
//   clk        sample clock; all logic on the rising edge
//   rst        synchronous active-high reset
//   rd_data    signed two's-complement ADC sample (SW bits)
//   rd_valid   rd_data valid this cycle
//   rd_enable  ready; a sample is accepted on rd_valid & rd_enable
//   diff_out   filtered line state: 10 positive, 01 negative, 00 idle
//   diff_valid one-cycle pulse per accepted sample, aligned with diff_out
//
// Pipeline: capture -> classify -> filter. A sample accepted at edge N
// shows up on diff_out/diff_valid at edge N+2.
module util_adc_to_diff #(
    parameter int          WORD_WIDTH = 1,
    parameter int          BYTE_WIDTH = 2,
    parameter int          POS_THRESH = 32,
    parameter int          NEG_THRESH = -32,
    parameter int unsigned HYST       = 8,
    parameter int          FILTER_LEN = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [WORD_WIDTH*BYTE_WIDTH*8-1:0]   rd_data,
    input  logic                                 rd_valid,
    output logic                                 rd_enable,
    output logic [1:0]                           diff_out,
    output logic                                 diff_valid
);

    localparam int SW = WORD_WIDTH * BYTE_WIDTH * 8;
    // One extra bit so threshold +/- HYST can never wrap.
    localparam int EW = SW + 1;

    localparam logic signed [EW-1:0] POS_T    = EW'(POS_THRESH);
    localparam logic signed [EW-1:0] NEG_T    = EW'(NEG_THRESH);
    localparam logic signed [EW-1:0] POS_HOLD = EW'(POS_THRESH - int'(HYST));
    localparam logic signed [EW-1:0] NEG_HOLD = EW'(NEG_THRESH + int'(HYST));
    localparam logic [3:0]           FL       = 4'(FILTER_LEN);

    localparam logic [1:0] C_IDLE = 2'b00;
    localparam logic [1:0] C_POS  = 2'b10;
    localparam logic [1:0] C_NEG  = 2'b01;

    logic          en_q,   en_d;
    logic          s0_v_q, s0_v_d;
    logic [SW-1:0] s0_data_q, s0_data_d;
    logic          s1_v_q, s1_v_d;
    logic [1:0]    s1_cls_q, s1_cls_d;
    logic [1:0]    diff_q, diff_d;
    logic [1:0]    cand_q, cand_d;
    logic [3:0]    cnt_q,  cnt_d;
    logic          dv_q,   dv_d;

    logic signed [EW-1:0] smp_x;
    logic [1:0]           cls;
    logic [3:0]           cnt_inc;

    assign smp_x   = {s0_data_q[SW-1], s0_data_q};
    assign cnt_inc = cnt_q + 4'd1;

    // Raw class of the captured sample against the current line state.
    always_comb begin
        cls = C_IDLE;
        unique case (diff_q)
            C_POS: begin
                if (smp_x >= POS_HOLD)   cls = C_POS;
                else if (smp_x <= NEG_T) cls = C_NEG;
            end
            C_NEG: begin
                if (smp_x <= NEG_HOLD)   cls = C_NEG;
                else if (smp_x >= POS_T) cls = C_POS;
            end
            default: begin
                if (smp_x >= POS_T)      cls = C_POS;
                else if (smp_x <= NEG_T) cls = C_NEG;
            end
        endcase
    end

    always_comb begin
        en_d      = 1'b1;
        s0_v_d    = rd_valid & en_q;
        s0_data_d = s0_data_q;
        if (rd_valid && en_q) begin
            s0_data_d = rd_data;
        end

        s1_v_d   = s0_v_q;
        s1_cls_d = s0_v_q ? cls : s1_cls_q;

        dv_d   = s1_v_q;
        diff_d = diff_q;
        cand_d = cand_q;
        cnt_d  = cnt_q;

        // Bubbles leave candidate/count untouched, so gaps in the
        // sample stream do not break a run of consecutive classes.
        if (s1_v_q) begin
            if (s1_cls_q == diff_q) begin
                cnt_d = 4'd0;
            end else if (s1_cls_q == cand_q) begin
                if (cnt_inc >= FL) begin
                    diff_d = s1_cls_q;
                    cnt_d  = 4'd0;
                end else begin
                    cnt_d  = cnt_inc;
                end
            end else begin
                cand_d = s1_cls_q;
                if (FL <= 4'd1) begin
                    diff_d = s1_cls_q;
                    cnt_d  = 4'd0;
                end else begin
                    cnt_d  = 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            s0_v_q    <= 1'b0;
            s0_data_q <= '0;
            s1_v_q    <= 1'b0;
            s1_cls_q  <= C_IDLE;
            diff_q    <= C_IDLE;
            cand_q    <= C_IDLE;
            cnt_q     <= 4'd0;
            dv_q      <= 1'b0;
        end else begin
            en_q      <= en_d;
            s0_v_q    <= s0_v_d;
            s0_data_q <= s0_data_d;
            s1_v_q    <= s1_v_d;
            s1_cls_q  <= s1_cls_d;
            diff_q    <= diff_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            dv_q      <= dv_d;
        end
    end

    assign rd_enable  = en_q;
    assign diff_out   = diff_q;
    assign diff_valid = dv_q;

endmodule

// File: tb/tb_util_adc_to_diff.sv
// tb_util_adc_to_diff: table-driven bench for util_adc_to_diff with a
// scoreboard of expected diff_out values, one per accepted sample.
module tb_util_adc_to_diff;

    logic        clk;
    logic        rst;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_enable;
    logic [1:0]  diff_out;
    logic        diff_valid;

    int tests;
    int fails;

    logic [1:0] exp_q[$];

    typedef struct {
        logic signed [15:0] data;
        int                 gap;
        logic [1:0]         exp;
    } vec_t;

    vec_t vecs[$];

    util_adc_to_diff dut (
        .clk        (clk),
        .rst        (rst),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_enable  (rd_enable),
        .diff_out   (diff_out),
        .diff_valid (diff_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Advance to the next falling edge and run the scoreboard there.
    task automatic tick();
        logic [1:0] e;
        @(negedge clk);
        chk("never_11", int'(diff_out == 2'b11), 0);
        if (diff_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_diff_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("diff_out", int'(diff_out), int'(e));
            end
        end
    endtask

    task automatic add(input int d, input int g, input logic [1:0] e);
        vec_t v;
        v.data = 16'(d);
        v.gap  = g;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic send(input vec_t v);
        rd_valid = 1'b0;
        for (int k = 0; k < v.gap; k++) tick();
        rd_valid = 1'b1;
        rd_data  = v.data;
        exp_q.push_back(v.exp);
        tick();
        rd_valid = 1'b0;
    endtask

    initial begin
        int lat_v[7];
        tests = 0;
        fails = 0;

        // Hysteresis (starting from 10 after the latency sequence).
        add(30, 2, 2'b10);
        add(30, 2, 2'b10);
        add(23, 2, 2'b10);
        add(23, 2, 2'b00);
        add(31, 2, 2'b00);
        add(31, 2, 2'b00);
        add(32, 2, 2'b00);
        add(32, 2, 2'b10);
        // Extremes with a direct flip.
        add(-32768, 2, 2'b10);
        add(-32768, 2, 2'b01);
        add(32767, 2, 2'b01);
        add(32767, 2, 2'b10);
        // Back to idle, then negative thresholds and hold band.
        add(0, 2, 2'b10);
        add(0, 2, 2'b00);
        add(-31, 2, 2'b00);
        add(-31, 2, 2'b00);
        add(-32, 2, 2'b00);
        add(-32, 2, 2'b01);
        add(-24, 2, 2'b01);
        add(-23, 2, 2'b01);
        add(-23, 2, 2'b00);
        // Long gap between two positives still counts as consecutive.
        add(64, 2, 2'b00);
        add(64, 6, 2'b10);

        // Reset with valid data pending.
        rst      = 1'b1;
        rd_valid = 1'b1;
        rd_data  = 16'd100;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_rd_enable", int'(rd_enable), 0);
            chk("rst_diff_out", int'(diff_out), 0);
            chk("rst_diff_valid", int'(diff_valid), 0);
        end
        rst = 1'b0;
        tick();
        chk("rd_enable_after_rst", int'(rd_enable), 1);
        rd_valid = 1'b0;
        tick();
        tick();

        // Latency: three back-to-back 64s.
        lat_v = '{0, 0, 0, 1, 1, 1, 0};
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("latency_diff_valid", int'(diff_valid), lat_v[i]);
            if (i == 4) chk("latency_diff_out", int'(diff_out), 2);
            rd_valid = (i < 3);
            rd_data  = 16'd64;
            if (i < 3) exp_q.push_back(i == 0 ? 2'b00 : 2'b10);
        end
        rd_valid = 1'b0;

        // Glitch: 0,64,0,0 stays idle.
        begin
            vec_t g;
            int   gd[4];
            gd = '{0, 64, 0, 0};
            // First return line to idle from 10.
            g.gap = 2; g.data = 16'd0; g.exp = 2'b10; send(g);
            g.exp = 2'b00; send(g);
            for (int i = 0; i < 4; i++) begin
                g.gap  = (i == 0) ? 2 : 0;
                g.data = 16'(gd[i]);
                g.exp  = 2'b00;
                send(g);
            end
        end
        // Bring line to 10 so the hysteresis table starts there.
        begin
            vec_t p;
            p.gap = 2; p.data = 16'd64; p.exp = 2'b00; send(p);
            p.exp = 2'b10; send(p);
        end

        foreach (vecs[i]) send(vecs[i]);

        // In-flight sample discarded by reset.
        tick();
        tick();
        rd_valid = 1'b1;
        rd_data  = 16'hFFC0;
        tick();
        rst      = 1'b1;
        rd_valid = 1'b0;
        tick();
        chk("midrst_diff_out", int'(diff_out), 0);
        chk("midrst_diff_valid", int'(diff_valid), 0);
        chk("midrst_rd_enable", int'(rd_enable), 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("post_rst_diff_out", int'(diff_out), 0);
        chk("pending_expected", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
